// File: rtl/rst_seq.sv
// rst_seq: reset receiver and sequencer.
// Takes a raw asynchronous active-low reset and releases a set of staged reset
// outputs synchronously, one stage after another, after a minimum hold time.
// A synchronous software request re-runs the release sequence.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset (assert async, release synced)
//   sw_rst_req  in   synchronous software reset request, sampled every edge
//   rst_out     out  [STAGES] staged resets, asserted level = ACTIVE_HIGH
//   ready       out  high once every rst_out bit is deasserted
//   sw_rst_cnt  out  [8] saturating count of accepted software requests
module rst_seq #(
    parameter int unsigned STAGES      = 3,
    parameter int unsigned SYNC_DEPTH  = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter bit          ACTIVE_HIGH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw_rst_req,
    output logic [STAGES-1:0] rst_out,
    output logic              ready,
    output logic [7:0]        sw_rst_cnt
);

    localparam int unsigned MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned SW   = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    logic [SYNC_DEPTH-1:0] r_sync;
    logic                  w_sync_out;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [SW-1:0]         r_stg;
    logic [SW-1:0]         w_stg_nxt;
    logic [STAGES-1:0]     r_rel;
    logic [STAGES-1:0]     w_rel_nxt;
    logic                  r_ready;
    logic                  w_ready_nxt;
    logic [7:0]            r_swcnt;
    logic [7:0]            w_swcnt_nxt;

    // Deassertion synchronizer: shifts in a constant 1, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign w_sync_out = r_sync[SYNC_DEPTH-1];

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ASSERT;
            r_cnt   <= '0;
            r_stg   <= '0;
            r_rel   <= '0;
            r_ready <= 1'b0;
            r_swcnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stg   <= w_stg_nxt;
            r_rel   <= w_rel_nxt;
            r_ready <= w_ready_nxt;
            r_swcnt <= w_swcnt_nxt;
        end
    end

    // Next-state logic. r_rel holds one bit per stage, 1 = released.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stg_nxt   = r_stg;
        w_rel_nxt   = r_rel;
        w_ready_nxt = r_ready;
        w_swcnt_nxt = r_swcnt;

        unique case (r_state)
            ST_ASSERT: begin
                // The edge that first sees the synchronized release already
                // counts as hold cycle 1, so stage 0 lands on edge
                // SYNC_DEPTH + HOLD_CYCLES.
                if (w_sync_out) begin
                    if (HOLD_CYCLES == 1) begin
                        w_rel_nxt[0] = 1'b1;
                        w_cnt_nxt    = '0;
                        if (STAGES == 1) begin
                            w_state_nxt = ST_DONE;
                            w_ready_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_RELEASE;
                            w_stg_nxt   = SW'(1);
                        end
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                    w_rel_nxt[0] = 1'b1;
                    w_cnt_nxt    = '0;
                    if (STAGES == 1) begin
                        w_state_nxt = ST_DONE;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                        w_stg_nxt   = SW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_RELEASE: begin
                if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                    // Loop-compare avoids a variable index into a 1-bit vector.
                    for (int k = 0; k < STAGES; k++) begin
                        if (SW'(k) == r_stg) begin
                            w_rel_nxt[k] = 1'b1;
                        end
                    end
                    w_cnt_nxt = '0;
                    if (r_stg == SW'(STAGES - 1)) begin
                        w_state_nxt = ST_DONE;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_stg_nxt = r_stg + SW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DONE: begin
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_ASSERT;
            end
        endcase

        // Software request overrides everything except the power-on ASSERT phase.
        if (sw_rst_req && (r_state != ST_ASSERT)) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
            w_stg_nxt   = '0;
            w_rel_nxt   = '0;
            w_ready_nxt = 1'b0;
            if (r_swcnt != 8'hFF) begin
                w_swcnt_nxt = r_swcnt + 8'd1;
            end
        end
    end

    assign rst_out    = ACTIVE_HIGH ? ~r_rel : r_rel;
    assign ready      = r_ready;
    assign sw_rst_cnt = r_swcnt;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: default instance plus a low-asserted
// single-stage instance with a one-cycle hold.
module tb_rst_seq;

    logic       clk;
    logic       rst_n;
    logic       sw_rst_req;
    logic [2:0] rst_out;
    logic       ready;
    logic [7:0] sw_rst_cnt;

    logic       sw2;
    logic [0:0] rst_out2;
    logic       ready2;
    logic [7:0] sw_rst_cnt2;

    int ntests = 0;
    int nfail  = 0;
    int e      = 0;
    int n0     = 0;

    rst_seq u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (sw_rst_req),
        .rst_out    (rst_out),
        .ready      (ready),
        .sw_rst_cnt (sw_rst_cnt)
    );

    rst_seq #(
        .STAGES      (1),
        .SYNC_DEPTH  (2),
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (4),
        .ACTIVE_HIGH (1'b0)
    ) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (sw2),
        .rst_out    (rst_out2),
        .ready      (ready2),
        .sw_rst_cnt (sw_rst_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to absolute edge number t of the current sequence, sample at +1.
    task automatic to_edge(input int t);
        while (e < t) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    // Reset for a few cycles, then release just after a posedge so the next
    // posedge is edge 1.
    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        e = 0;
    endtask

    initial begin
        rst_n      = 1'b0;
        sw_rst_req = 1'b0;
        sw2        = 1'b0;

        // Reset state, no release yet
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_in_reset", 32'(rst_out), 32'h7);
        chk("ready_in_reset", 32'(ready), 32'h0);
        chk("cnt_in_reset", 32'(sw_rst_cnt), 32'h0);
        chk("dut2_out_in_reset", 32'(rst_out2), 32'h0);
        chk("dut2_ready_in_reset", 32'(ready2), 32'h0);

        // Power-on sequence
        do_reset();
        to_edge(2);
        chk("dut2_out_e2", 32'(rst_out2), 32'h0);
        chk("dut2_ready_e2", 32'(ready2), 32'h0);
        to_edge(3);
        chk("dut2_out_e3", 32'(rst_out2), 32'h1);
        chk("dut2_ready_e3", 32'(ready2), 32'h1);
        to_edge(17);
        chk("po_e17", 32'(rst_out), 32'h7);
        to_edge(18);
        chk("po_e18", 32'(rst_out), 32'h6);
        to_edge(21);
        chk("po_e21", 32'(rst_out), 32'h6);
        to_edge(22);
        chk("po_e22", 32'(rst_out), 32'h4);
        to_edge(25);
        chk("po_e25", 32'(rst_out), 32'h4);
        chk("po_ready_e25", 32'(ready), 32'h0);
        to_edge(26);
        chk("po_e26", 32'(rst_out), 32'h0);
        chk("po_ready_e26", 32'(ready), 32'h1);
        chk("po_cnt", 32'(sw_rst_cnt), 32'h0);

        // Mid-sequence rst_n pulse: asserts with no clock edge
        do_reset();
        to_edge(20);
        chk("mid_e20", 32'(rst_out), 32'h6);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_out", 32'(rst_out), 32'h7);
        chk("mid_async_ready", 32'(ready), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        e = 0;
        to_edge(17);
        chk("mid_rerun_e17", 32'(rst_out), 32'h7);
        to_edge(18);
        chk("mid_rerun_e18", 32'(rst_out), 32'h6);
        to_edge(26);
        chk("mid_rerun_ready", 32'(ready), 32'h1);

        // Single sw request in DONE at edge n0
        to_edge(30);
        sw_rst_req = 1'b1;
        n0 = 31;
        to_edge(n0);
        sw_rst_req = 1'b0;
        chk("sw1_out_N", 32'(rst_out), 32'h7);
        chk("sw1_ready_N", 32'(ready), 32'h0);
        chk("sw1_cnt", 32'(sw_rst_cnt), 32'h1);
        to_edge(n0 + 15);
        chk("sw1_N15", 32'(rst_out), 32'h7);
        to_edge(n0 + 16);
        chk("sw1_N16", 32'(rst_out), 32'h6);
        to_edge(n0 + 20);
        chk("sw1_N20", 32'(rst_out), 32'h4);
        to_edge(n0 + 23);
        chk("sw1_ready_N23", 32'(ready), 32'h0);
        to_edge(n0 + 24);
        chk("sw1_N24", 32'(rst_out), 32'h0);
        chk("sw1_ready_N24", 32'(ready), 32'h1);

        // sw request during ASSERT is ignored
        do_reset();
        sw_rst_req = 1'b1;
        to_edge(2);
        sw_rst_req = 1'b0;
        chk("swa_cnt", 32'(sw_rst_cnt), 32'h0);
        to_edge(17);
        chk("swa_e17", 32'(rst_out), 32'h7);
        to_edge(18);
        chk("swa_e18", 32'(rst_out), 32'h6);
        to_edge(26);
        chk("swa_e26", 32'(rst_out), 32'h0);
        chk("swa_ready", 32'(ready), 32'h1);

        // sw request held for 3 edges in DONE
        to_edge(29);
        sw_rst_req = 1'b1;
        n0 = 30;
        to_edge(n0 + 2);
        sw_rst_req = 1'b0;
        chk("swh_cnt", 32'(sw_rst_cnt), 32'h3);
        to_edge(n0 + 17);
        chk("swh_N17", 32'(rst_out), 32'h7);
        to_edge(n0 + 18);
        chk("swh_N18", 32'(rst_out), 32'h6);

        // Saturation of the request counter
        for (int i = 0; i < 300; i++) begin
            sw_rst_req = 1'b1;
            to_edge(e + 1);
            sw_rst_req = 1'b0;
            to_edge(e + 1);
            if (i == 99) chk("sat_cnt_103", 32'(sw_rst_cnt), 32'd103);
        end
        chk("sat_cnt_255", 32'(sw_rst_cnt), 32'd255);
        chk("sat_out", 32'(rst_out), 32'h7);

        // Sub-cycle rst_n glitch in DONE clears everything and reruns
        to_edge(e + 30);
        chk("gl_pre_ready", 32'(ready), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("gl_out", 32'(rst_out), 32'h7);
        chk("gl_ready", 32'(ready), 32'h0);
        chk("gl_cnt", 32'(sw_rst_cnt), 32'h0);
        chk("gl_dut2_out", 32'(rst_out2), 32'h0);
        #2 rst_n = 1'b1;
        e = 0;
        to_edge(17);
        chk("gl_e17", 32'(rst_out), 32'h7);
        to_edge(18);
        chk("gl_e18", 32'(rst_out), 32'h6);
        to_edge(26);
        chk("gl_e26", 32'(rst_out), 32'h0);
        chk("gl_ready_e26", 32'(ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset receiver/sequencer. Takes a raw asynchronous active-low board/bench reset and drives a set of staged, synchronously released reset outputs for downstream blocks.
- Assertion is immediate (asynchronous). Deassertion is synchronized, held for a minimum time, then released stage by stage.
- Also accepts a synchronous software reset request that re-runs the release sequence.
- Sits between a reset source and the DUT/clock-domain logic. `ready` flags that all stages are out of reset.

Parameters:
- STAGES, 3: number of sequenced reset outputs; legal 1..8.
- SYNC_DEPTH, 2: flops in the rst_n deassertion synchronizer; legal >=2.
- HOLD_CYCLES, 16: cycles after synchronized release (or sw request) before rst_out[0] releases; legal >=1.
- GAP_CYCLES, 4: cycles between successive stage releases; legal >=1.
- ACTIVE_HIGH, 1: asserted level of rst_out (1 = high-asserted, 0 = low-asserted).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- sw_rst_req  input  1  synchronous software reset request, sampled each rising edge.
- rst_out  output  STAGES  staged reset outputs; bit k releases after bit k-1.
- ready  output  1  high when all rst_out bits are deasserted.
- sw_rst_cnt  output  8  count of accepted sw requests; saturating.

Behaviour:
- Reset state (rst_n low, asynchronous, no clock needed):
  - all rst_out = ACTIVE_HIGH; ready = 0; sw_rst_cnt = 0.
  - Synchronizer cleared; FSM = ASSERT; hold/gap counters = 0.
- Synchronizer: SYNC_DEPTH-flop shift of constant 1, async cleared by rst_n.
- FSM states: ASSERT, HOLD, RELEASE, DONE.
  - ASSERT -> HOLD when synchronizer output is 1.
  - HOLD: counts HOLD_CYCLES, then releases rst_out[0] -> RELEASE (if STAGES>1) or DONE.
  - RELEASE: counts GAP_CYCLES per stage and releases rst_out[k] in turn. Releasing rst_out[STAGES-1] -> DONE.
  - DONE: ready = 1.
- Power-on timing: number rising edges from 1, where edge 1 is the first rising edge at which rst_n is sampled high.
  - rst_out[k] deasserts at edge SYNC_DEPTH + HOLD_CYCLES + k*GAP_CYCLES.
  - ready rises at the same edge as rst_out[STAGES-1].
  - Defaults: stage0 at edge 18, stage1 at 22, stage2 at 26, ready at 26.
- rst_out and ready are registered; they change only on rising edges, except asynchronous assertion via rst_n.
- Stages deassert in strictly increasing index order. A higher index is never deasserted while a lower index is asserted.
- sw_rst_req:
  - Accepted when sampled high in HOLD, RELEASE or DONE.
  - At accepting edge N: all rst_out asserted, ready = 0, FSM = HOLD, counters cleared, sw_rst_cnt += 1 (saturates at 255).
  - rst_out[k] then deasserts at edge N + HOLD_CYCLES + k*GAP_CYCLES. There is no synchronizer delay for a sw request.
  - Held high for multiple cycles: each sampled-high edge is a separate accepted request. The hold restarts each time and the count increments each time.
  - Ignored in ASSERT; sw_rst_cnt unchanged.
- rst_n low at any time, including mid-HOLD/RELEASE/DONE:
  - Immediate asynchronous return to the reset state (sw_rst_cnt cleared).
  - Full power-on sequence on the next release.
- rst_n glitch shorter than one clock period still asserts all outputs and clears the synchronizer. The full sequence reruns.
- Counters are sized to max(HOLD_CYCLES, GAP_CYCLES). No wrap-around is permitted before terminal count.

Test Plan:
- Power-on, defaults: hold rst_n low 5 cycles, release -> rst_out=3'b111 until edge 18, then 3'b110; 3'b100 at edge 22; 3'b000 and ready=1 at edge 26; sw_rst_cnt=0.
- Mid-sequence rst_n pulse: drop rst_n at edge 20 (stage0 already released) -> rst_out=3'b111 and ready=0 with no clock edge; after re-release, stage0 at edge 18 of the new count.
- sw request in DONE: 1-cycle sw_rst_req at edge N -> rst_out=3'b111 at N; releases at N+16, N+20, N+24; ready at N+24; sw_rst_cnt=1.
- sw request during ASSERT (before edge 2): rst_out timing identical to the power-on case; sw_rst_cnt stays 0.
- sw request held 3 cycles from edge N in DONE -> sw_rst_cnt += 3; stage0 releases at N+2+16; 300 single requests -> sw_rst_cnt=255.
- ACTIVE_HIGH=0, STAGES=1, HOLD_CYCLES=1 -> rst_out=0 in reset; goes to 1 with ready=1 at edge SYNC_DEPTH+1 = 3.
